// File: rtl/updi_phy_pkg.sv
// Shared constants and types for the UPDI PHY receive path.
package updi_phy_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Bit positions inside error_flags.
    localparam int ERR_PARITY = 0;
    localparam int ERR_STOP   = 1;
    localparam int ERR_START  = 2;
    localparam int ERR_BREAK  = 3;

    typedef enum logic {
        RUN    = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/updi_sat_counter.sv
// Saturating up-counter; a clear takes precedence over an increment.
module updi_sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/updi_frame_checker.sv
// Checks deserialised UPDI frames for start/stop/parity/BREAK errors, extracts the
// data byte, keeps saturating error statistics and locks after repeated bad frames.
module updi_frame_checker
    import updi_phy_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = PAR_EVEN,
    parameter int STOP_BITS   = 2,
    parameter int CNT_WIDTH   = 8,
    parameter int ERR_LIMIT   = 3,
    localparam int FRAME_W    = 1 + DATA_BITS + ((PARITY_MODE != PAR_NONE) ? 1 : 0) + STOP_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FRAME_W-1:0]   frame_in,
    input  logic                 frame_valid,
    input  logic                 clr_stats,
    input  logic                 clr_lock,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic [3:0]           error_flags,
    output logic                 error_valid,
    output logic                 lock,
    output logic [CNT_WIDTH-1:0] parity_cnt,
    output logic [CNT_WIDTH-1:0] stop_cnt,
    output logic [CNT_WIDTH-1:0] start_cnt,
    output logic [CNT_WIDTH-1:0] break_cnt,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    localparam int CONS_W = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT + 1) : 1;

    state_e                 state_q, state_d;
    logic [CONS_W-1:0]      cons_q, cons_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   dv_q, dv_d;
    logic                   ev_q, ev_d;
    logic [3:0]             flags_q, flags_d;

    logic [DATA_BITS-1:0]   data_w;
    logic [STOP_BITS-1:0]   stop_w;
    logic                   par_bit;
    logic                   par_sum;
    logic                   parity_err;
    logic                   break_det;
    logic                   any_err;
    logic [3:0]             flags_now;

    // With parity disabled the bit after the data is a stop bit; it is ignored below.
    assign data_w    = frame_in[DATA_BITS:1];
    assign par_bit   = frame_in[DATA_BITS+1];
    assign stop_w    = frame_in[FRAME_W-1 -: STOP_BITS];
    assign break_det = (frame_in == '0);
    assign par_sum   = (^data_w) ^ par_bit;

    always_comb begin
        parity_err = 1'b0;
        if (PARITY_MODE == PAR_EVEN) begin
            parity_err = par_sum;
        end else if (PARITY_MODE == PAR_ODD) begin
            parity_err = ~par_sum;
        end
    end

    always_comb begin
        flags_now = '0;
        if (break_det) begin
            flags_now[ERR_BREAK] = 1'b1;
        end else begin
            flags_now[ERR_START]  = frame_in[0];
            flags_now[ERR_STOP]   = ~(&stop_w);
            flags_now[ERR_PARITY] = parity_err;
        end
    end

    assign any_err = flags_now[ERR_START] | flags_now[ERR_STOP] | flags_now[ERR_PARITY];

    always_comb begin
        state_d = state_q;
        cons_d  = cons_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        ev_d    = 1'b0;
        flags_d = '0;
        if (frame_valid) begin
            ev_d    = 1'b1;
            flags_d = flags_now;
            data_d  = data_w;
        end
        case (state_q)
            RUN: begin
                if (frame_valid) begin
                    if (break_det) begin
                        cons_d = '0;
                    end else if (any_err) begin
                        if (cons_q == CONS_W'(ERR_LIMIT - 1)) begin
                            cons_d  = '0;
                            state_d = LOCKED;
                        end else begin
                            cons_d = cons_q + 1'b1;
                        end
                    end else begin
                        dv_d   = 1'b1;
                        cons_d = '0;
                    end
                end
            end
            LOCKED: begin
                // An error frame arriving with clr_lock is the first of a new run.
                if (clr_lock) begin
                    state_d = RUN;
                    cons_d  = '0;
                    if (frame_valid && any_err) begin
                        if (ERR_LIMIT == 1) begin
                            state_d = LOCKED;
                        end else begin
                            cons_d = CONS_W'(1);
                        end
                    end
                end else if (frame_valid && break_det) begin
                    state_d = RUN;
                    cons_d  = '0;
                end
            end
            default: begin
                state_d = RUN;
                cons_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cons_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            ev_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cons_q  <= cons_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            ev_q    <= ev_d;
            flags_q <= flags_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = dv_q;
    assign error_valid = ev_q;
    assign error_flags = flags_q;
    assign lock        = (state_q == LOCKED);

    updi_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_parity_cnt (
        .clk_i(clk), .rst_i(reset), .inc_i(frame_valid & flags_now[ERR_PARITY]),
        .clr_i(clr_stats), .cnt_o(parity_cnt)
    );

    updi_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stop_cnt (
        .clk_i(clk), .rst_i(reset), .inc_i(frame_valid & flags_now[ERR_STOP]),
        .clr_i(clr_stats), .cnt_o(stop_cnt)
    );

    updi_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_start_cnt (
        .clk_i(clk), .rst_i(reset), .inc_i(frame_valid & flags_now[ERR_START]),
        .clr_i(clr_stats), .cnt_o(start_cnt)
    );

    updi_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_break_cnt (
        .clk_i(clk), .rst_i(reset), .inc_i(frame_valid & flags_now[ERR_BREAK]),
        .clr_i(clr_stats), .cnt_o(break_cnt)
    );

    updi_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_frame_cnt (
        .clk_i(clk), .rst_i(reset), .inc_i(frame_valid),
        .clr_i(clr_stats), .cnt_o(frame_cnt)
    );

endmodule
